imm_operand_encoder: RTL and testbench

- Iterative encoder for the ARM data-processing 32-bit immediate form. The shifter decodes {rotate_imm, immed_8} into a value by rotating right; this block takes a 32-bit constant and searches for the 12-bit shifter_operand that reproduces it.
- Used by the assembler/test-vector path and by the operand-forming logic to check that constants are encodable.
- Tests one rotation per cycle and reports the canonical (smallest rotate_imm) encoding, or reports that none exists.

---
 rtl/arm_shift_pkg.sv | 32 +++
 rtl/rot_left_32.sv | 19 +
 rtl/imm_operand_encoder.sv | 121 ++++++++++++
 tb/tb_imm_operand_encoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_shift_pkg.sv
// Shared definitions for the ARM shifter datapath: encoder FSM states,
// rotate-immediate geometry and the shift-type codes used by the shifter.
package arm_shift_pkg;

  // Number of rotate_imm candidates; candidate r rotates by 2*r.
  localparam int unsigned ROT_STEPS = 16;
  // Width of immed_8.
  localparam int unsigned IMM_BITS  = 8;
  // Width of rotate_imm.
  localparam int unsigned ROT_W     = $clog2(ROT_STEPS);
  // Width of shifter_operand {rotate_imm, immed_8}.
  localparam int unsigned OPERAND_W = ROT_W + IMM_BITS;
  // Data path width and rotate amount width.
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned AMT_W     = $clog2(DATA_W);

  // Immediate encoder states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_DONE   = 2'b10
  } enc_state_e;

  // Shift-type codes shared with the shifter.
  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_type_e;

endpackage

// File: rtl/rot_left_32.sv
// 32-bit rotate left with wrap.
// Ports: value (data in), amount (rotate distance 0..31), rotated_c (result).
module rot_left_32
  import arm_shift_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [AMT_W-1:0]  amount,
  output logic [DATA_W-1:0] rotated_c
);

  logic [2*DATA_W-1:0] doubled;

  // Shifting a doubled copy left leaves the wrapped result in the upper half.
  always_comb begin
    doubled   = {value, value} << amount;
    rotated_c = doubled[2*DATA_W-1:DATA_W];
  end

endmodule

// File: rtl/imm_operand_encoder.sv
// Iterative search for the 12-bit data-processing immediate {rotate_imm,
// immed_8} that reproduces a 32-bit constant; one rotation tested per cycle,
// smallest rotate_imm wins.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              request, sampled only while idle
//   value, carryFlag   constant and C flag, latched on accept
//   busy               high while searching
//   done               one-cycle result strobe
//   found              constant is encodable (held until next accept)
//   shifter_operand    {rotate_imm, immed_8}, 0 when not found
//   carry              shifter carry-out of the encoding, 0 when not found
module imm_operand_encoder
  import arm_shift_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    value,
  input  logic                 carryFlag,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [OPERAND_W-1:0] shifter_operand,
  output logic                 carry
);

  enc_state_e           state_q, state_d;
  logic [ROT_W-1:0]     r_q, r_d;
  logic [DATA_W-1:0]    value_q, value_d;
  logic                 cflag_q, cflag_d;
  logic                 busy_d, done_d, found_d, carry_d;
  logic [OPERAND_W-1:0] operand_d;
  logic [DATA_W-1:0]    cand_c;
  logic                 hit_c;

  // Candidate for rotate_imm=r: undo the decode rotate of 2*r.
  rot_left_32 u_rol (
    .value     (value_q),
    .amount    (AMT_W'({r_q, 1'b0})),
    .rotated_c (cand_c)
  );

  assign hit_c = (cand_c[DATA_W-1:IMM_BITS] == '0);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    value_d   = value_q;
    cflag_d   = cflag_q;
    found_d   = found;
    operand_d = shifter_operand;
    carry_d   = carry;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          value_d   = value;
          cflag_d   = carryFlag;
          r_d       = '0;
          found_d   = 1'b0;
          operand_d = '0;
          carry_d   = 1'b0;
          state_d   = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (hit_c) begin
          found_d   = 1'b1;
          operand_d = {r_q, cand_c[IMM_BITS-1:0]};
          // Unrotated immediates pass the C flag through.
          carry_d   = (r_q == '0) ? cflag_q : value_q[DATA_W-1];
          state_d   = ST_DONE;
        end else if (r_q == ROT_W'(ROT_STEPS - 1)) begin
          found_d   = 1'b0;
          operand_d = '0;
          carry_d   = 1'b0;
          state_d   = ST_DONE;
        end else begin
          r_d = r_q + ROT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SEARCH);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      r_q             <= '0;
      value_q         <= '0;
      cflag_q         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      found           <= 1'b0;
      shifter_operand <= '0;
      carry           <= 1'b0;
    end else begin
      state_q         <= state_d;
      r_q             <= r_d;
      value_q         <= value_d;
      cflag_q         <= cflag_d;
      busy            <= busy_d;
      done            <= done_d;
      found           <= found_d;
      shifter_operand <= operand_d;
      carry           <= carry_d;
    end
  end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Self-checking bench for imm_operand_encoder: directed vectors with literal
// expectations plus a cycle-level reference model compared every cycle.
module tb_imm_operand_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        carryFlag;
  logic        busy, done, found, carry;
  logic [11:0] shifter_operand;

  int errors = 0;
  int checks = 0;

  imm_operand_encoder dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .value           (value),
    .carryFlag       (carryFlag),
    .busy            (busy),
    .done            (done),
    .found           (found),
    .shifter_operand (shifter_operand),
    .carry           (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Reference: exhaustively decode every (rotate_imm, immed_8) pair in
  // ascending rotate order and keep the first that reproduces the value.
  function automatic void model_encode(input logic [31:0] v, input logic cf,
                                       output logic f, output logic [11:0] op,
                                       output logic c, output int dcyc);
    f = 1'b0; op = 12'h000; c = 1'b0; dcyc = 17;
    for (int r = 0; r < 16; r++) begin
      for (int imm = 0; imm < 256; imm++) begin
        if (!f && ror32(32'(imm), 2 * r) == v) begin
          f    = 1'b1;
          op   = {4'(r), 8'(imm)};
          c    = (r == 0) ? cf : v[31];
          dcyc = r + 2;
        end
      end
    end
  endfunction

  // Cycle-level model: phase 0 idle, 1 searching, 2 done strobe.
  int          m_phase = 0;
  int          m_cyc = 0;
  int          m_dcyc = 0;
  logic        m_f, m_c;
  logic [11:0] m_op;
  logic        model_on = 1'b0;
  logic        exp_busy = 1'b0, exp_done = 1'b0, exp_found = 1'b0, exp_carry = 1'b0;
  logic [11:0] exp_op = 12'h000;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; model_on = 1'b1;
      exp_busy = 1'b0; exp_done = 1'b0; exp_found = 1'b0; exp_op = 12'h000; exp_carry = 1'b0;
    end else if (model_on) begin
      case (m_phase)
        0: begin
          exp_done = 1'b0;
          if (start) begin
            model_encode(value, carryFlag, m_f, m_op, m_c, m_dcyc);
            m_phase = 1; m_cyc = 1;
            exp_busy = 1'b1; exp_found = 1'b0; exp_op = 12'h000; exp_carry = 1'b0;
          end
        end
        1: begin
          m_cyc++;
          if (m_cyc == m_dcyc) begin
            m_phase = 2;
            exp_busy = 1'b0; exp_done = 1'b1;
            exp_found = m_f; exp_op = m_op; exp_carry = m_c;
          end
        end
        default: begin
          m_phase = 0; exp_done = 1'b0;
        end
      endcase
    end
  end

  // Compare process: every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_on) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("found", 32'(found), 32'(exp_found));
      chk("operand", 32'(shifter_operand), 32'(exp_op));
      chk("carry", 32'(carry), 32'(exp_carry));
    end
  end

  // Issue one request and wait for done; returns the cycle done was seen.
  task automatic issue(input logic [31:0] v, input logic cf, output int dcyc);
    int cyc;
    @(negedge clk);
    value = v; carryFlag = cf; start = 1'b1;
    @(negedge clk);
    start = 1'b0; value = ~v; carryFlag = ~cf;
    cyc = 1;
    while (!done && cyc < 25) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      chk("done_timeout", 32'(cyc), 32'(0));
      dcyc = -1;
    end else begin
      dcyc = cyc;
    end
  endtask

  // Directed vector: DUT and model both pinned to literal expectations.
  task automatic run_vec(input string name, input logic [31:0] v, input logic cf,
                         input logic lf, input logic [11:0] lop, input logic lc, input int ldc);
    int dc, mdc;
    logic mf, mc;
    logic [11:0] mop;
    issue(v, cf, dc);
    chk({name, "_cycle"}, 32'(dc), 32'(ldc));
    chk({name, "_found"}, 32'(found), 32'(lf));
    chk({name, "_op"}, 32'(shifter_operand), 32'(lop));
    chk({name, "_carry"}, 32'(carry), 32'(lc));
    model_encode(v, cf, mf, mop, mc, mdc);
    chk({name, "_model"}, {mf, mc, 2'b00, mop, 16'(mdc)}, {lf, lc, 2'b00, lop, 16'(ldc)});
    @(negedge clk);
    chk({name, "_held"}, {found, carry, 18'(0), shifter_operand}, {lf, lc, 18'(0), lop});
  endtask

  initial begin
    int dc, ndone;
    logic [31:0] v;
    reset = 1'b1; start = 1'b0; value = 32'h0; carryFlag = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {28'(0), busy, done, found, carry}, 32'h0);
    chk("reset_op", 32'(shifter_operand), 32'h0);
    reset = 1'b0;

    run_vec("ff",      32'h000000FF, 1'b1, 1'b1, 12'h0FF, 1'b1, 2);
    run_vec("3fc",     32'h3FC00000, 1'b0, 1'b1, 12'h5FF, 1'b0, 7);
    run_vec("f00f",    32'hF000000F, 1'b0, 1'b1, 12'h2FF, 1'b1, 4);
    run_vec("four",    32'h00000004, 1'b0, 1'b1, 12'h004, 1'b0, 2);
    run_vec("x104",    32'h00000104, 1'b0, 1'b1, 12'hF41, 1'b0, 17);
    run_vec("x101",    32'h00000101, 1'b1, 1'b0, 12'h000, 1'b0, 17);
    run_vec("zero",    32'h00000000, 1'b1, 1'b1, 12'h000, 1'b1, 2);

    // Second start mid-search with a different value is ignored.
    @(negedge clk);
    value = 32'h3FC00000; carryFlag = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    value = 32'h000000FF; carryFlag = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dc = 0;
    for (int c = 4; c < 24; c++) begin
      if (done) begin ndone++; dc = c; end
      if (dc == c) chk("restart_op", 32'(shifter_operand), 32'h5FF);
      @(negedge clk);
    end
    chk("restart_ndone", 32'(ndone), 32'd1);
    chk("restart_cycle", 32'(dc), 32'd7);

    // Reset mid-search discards the search.
    @(negedge clk);
    value = 32'h00000101; carryFlag = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_outs", {found, carry, 18'(0), shifter_operand}, 32'h0);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("rst_mid_ndone", 32'(ndone), 32'd0);
    run_vec("after_rst", 32'h3FC00000, 1'b1, 1'b1, 12'h5FF, 1'b0, 7);

    // Sweep: half constructed encodable values, half raw random values.
    for (int i = 0; i < 2000; i++) begin
      if (i % 2 == 0) v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
      else            v = $urandom;
      issue(v, 1'($urandom), dc);
      if (found) chk("sweep_decode",
                     ror32(32'(shifter_operand[7:0]), 2 * int'(shifter_operand[11:8])), v);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
